// File: rtl/tile_board_memory.sv
// -----------------------------------------------------------------------------
// tile_board_memory
//
// Cell store for a tile board. It is made of an edge ring of N_EDGE cells
// (cells 0..N_EDGE-1) followed by N_CENTER center cells. The edge ring can be
// rotated one position per cycle. The center cells are never rotated.
//
// Ports
//   clk        : single clock; all logic on the rising edge
//   rst        : synchronous active-high reset; overrides every other input
//   load       : bulk-load strobe (cell 0 = MSB slice of edge_in)
//   edge_in    : edge-ring bulk data, N_EDGE*CELL_W bits
//   center_in  : center bulk data, N_CENTER*CELL_W bits
//   wr_en      : single-cell write strobe
//   wr_addr    : write address; addresses past the last cell are ignored
//   wr_data    : write data
//   rd_addr    : read address
//   rd_data    : registered read data, 1-cycle latency, read-before-write,
//                0 for addresses past the last cell
//   rot_start  : edge-ring rotation request
//   rot_steps  : number of single-position steps (0 = no-op completion)
//   rot_dir    : 0 = forward (new[i] = old[i-1]), 1 = reverse (new[i] = old[i+1])
//   busy       : rotation in progress
//   done       : one-cycle completion pulse
//
// Request handshake: the block takes requests only in IDLE. There is no
// ready signal. In IDLE, one strobe is accepted per cycle, with priority
// load > rot_start > wr_en. Any strobe that arrives in ROTATE or DONE is
// dropped and is not queued. When busy is high, further requests are dropped.
// -----------------------------------------------------------------------------
module tile_board_memory #(
   parameter int CELL_W   = 4,
   parameter int N_EDGE   = 24,
   parameter int N_CENTER = 12,
   parameter int ADDR_W   = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic [N_EDGE*CELL_W-1:0]   edge_in,
   input  logic [N_CENTER*CELL_W-1:0] center_in,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [CELL_W-1:0]          wr_data,
   input  logic [ADDR_W-1:0]          rd_addr,
   output logic [CELL_W-1:0]          rd_data,
   input  logic                       rot_start,
   input  logic [ADDR_W-1:0]          rot_steps,
   input  logic                       rot_dir,
   output logic                       busy,
   output logic                       done
);

   localparam int N_CELLS = N_EDGE + N_CENTER;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROTATE = 2'd1,
      DONE   = 2'd2
   } state_e;

   state_e              state_q;
   logic [ADDR_W-1:0]   steps_q;   // rotation steps still to perform
   logic                dir_q;
   logic                busy_q;
   logic                done_q;

   logic [CELL_W-1:0]   cells_q [N_CELLS];
   logic [CELL_W-1:0]   cells_d [N_CELLS];
   logic [CELL_W-1:0]   rd_q;
   logic [CELL_W-1:0]   rd_d;

   // ---------------------------------------------------------------------
   // Control FSM with registered busy/done
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         steps_q <= '0;
         dir_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               // A load in the same cycle takes priority over the rotation request.
               if (!load && rot_start) begin
                  steps_q <= rot_steps;
                  dir_q   <= rot_dir;
                  if (rot_steps != '0) begin
                     state_q <= ROTATE;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            ROTATE: begin
               steps_q <= steps_q - ADDR_W'(1);
               if (steps_q == ADDR_W'(1)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Next cell contents
   // ---------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < N_CELLS; i++) begin
         cells_d[i] = cells_q[i];
      end
      if (state_q == IDLE) begin
         if (load) begin
            for (int k = 0; k < N_EDGE; k++) begin
               cells_d[k] = edge_in[(N_EDGE-k)*CELL_W-1 -: CELL_W];
            end
            for (int j = 0; j < N_CENTER; j++) begin
               cells_d[N_EDGE+j] = center_in[(N_CENTER-j)*CELL_W-1 -: CELL_W];
            end
         end else if (!rot_start && wr_en) begin
            // An address past the last cell matches no cell, so the write is dropped.
            for (int i = 0; i < N_CELLS; i++) begin
               if (wr_addr == ADDR_W'(i)) begin
                  cells_d[i] = wr_data;
               end
            end
         end
      end else if (state_q == ROTATE) begin
         for (int i = 0; i < N_EDGE; i++) begin
            if (dir_q) begin
               cells_d[i] = cells_q[(i + 1) % N_EDGE];
            end else begin
               cells_d[i] = cells_q[(i + N_EDGE - 1) % N_EDGE];
            end
         end
      end
   end

   // Read mux from the pre-edge contents; an address past the last cell returns 0.
   always_comb begin
      rd_d = '0;
      for (int i = 0; i < N_CELLS; i++) begin
         if (rd_addr == ADDR_W'(i)) begin
            rd_d = cells_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CELLS; i++) begin
            cells_q[i] <= '0;
         end
         rd_q <= '0;
      end else begin
         for (int i = 0; i < N_CELLS; i++) begin
            cells_q[i] <= cells_d[i];
         end
         rd_q <= rd_d;
      end
   end

   assign rd_data = rd_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_tile_board_memory.sv
module tb_tile_board_memory;

  localparam int CELL_W   = 4;
  localparam int N_EDGE   = 24;
  localparam int N_CENTER = 12;
  localparam int ADDR_W   = 6;
  localparam int N_CELLS  = N_EDGE + N_CENTER;

  logic                       clk;
  logic                       rst;
  logic                       load;
  logic [N_EDGE*CELL_W-1:0]   edge_in;
  logic [N_CENTER*CELL_W-1:0] center_in;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [CELL_W-1:0]          wr_data;
  logic [ADDR_W-1:0]          rd_addr;
  logic [CELL_W-1:0]          rd_data;
  logic                       rot_start;
  logic [ADDR_W-1:0]          rot_steps;
  logic                       rot_dir;
  logic                       busy;
  logic                       done;

  tile_board_memory #(
    .CELL_W   (CELL_W),
    .N_EDGE   (N_EDGE),
    .N_CENTER (N_CENTER),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .edge_in   (edge_in),
    .center_in (center_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rot_start (rot_start),
    .rot_steps (rot_steps),
    .rot_dir   (rot_dir),
    .busy      (busy),
    .done      (done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [CELL_W-1:0] exp_cells [N_CELLS];
  logic [CELL_W-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CELL_W-1:0] model_rd(input int a);
    if (a < N_CELLS) return exp_cells[a];
    return '0;
  endfunction

  // Model edge-ring rotation: forward by k means new[i] = old[i-k].
  task automatic model_rotate(input int steps, input bit dir);
    logic [CELL_W-1:0] old [N_EDGE];
    int k;
    k = steps % N_EDGE;
    for (int i = 0; i < N_EDGE; i++) old[i] = exp_cells[i];
    for (int i = 0; i < N_EDGE; i++) begin
      if (!dir) exp_cells[i] = old[(i - k + N_EDGE) % N_EDGE];
      else      exp_cells[i] = old[(i + k) % N_EDGE];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N_CELLS; i++) exp_cells[i] = '0;
  endtask

  // ---------------- driver tasks (all start and end just after a negedge) ----
  task automatic read_one(input int a, input logic [CELL_W-1:0] exp, input string tag);
    rd_addr = ADDR_W'(a);
    @(negedge clk);
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  // Pipelined sweep over every cell plus a few addresses past the end.
  task automatic sweep(input string tag);
    rd_addr = '0;
    exp_q.push_back(model_rd(0));
    for (int a = 1; a < N_CELLS + 6; a++) begin
      @(negedge clk);
      chk(tag, 32'(rd_data), 32'(exp_q.pop_front()));
      rd_addr = ADDR_W'(a);
      exp_q.push_back(model_rd(a));
    end
    @(negedge clk);
    chk(tag, 32'(rd_data), 32'(exp_q.pop_front()));
  endtask

  task automatic do_load(input logic [N_EDGE*CELL_W-1:0] e,
                         input logic [N_CENTER*CELL_W-1:0] c, input bit extra);
    logic [N_EDGE*CELL_W-1:0]   te;
    logic [N_CENTER*CELL_W-1:0] tc;
    load = 1'b1; edge_in = e; center_in = c;
    if (extra) begin
      wr_en = 1'b1; wr_addr = 6'd5; wr_data = 4'hF;
      rot_start = 1'b1; rot_steps = 6'd3; rot_dir = 1'b0;
    end
    @(negedge clk);
    load = 1'b0; wr_en = 1'b0; rot_start = 1'b0;
    for (int k = 0; k < N_EDGE; k++) begin
      te = e >> ((N_EDGE - 1 - k) * CELL_W);
      exp_cells[k] = te[CELL_W-1:0];
    end
    for (int j = 0; j < N_CENTER; j++) begin
      tc = c >> ((N_CENTER - 1 - j) * CELL_W);
      exp_cells[N_EDGE+j] = tc[CELL_W-1:0];
    end
    if (extra) begin
      chk("load_prio_busy0", 32'(busy), 0);
      @(negedge clk);
      chk("load_prio_busy1", 32'(busy), 0);
      chk("load_prio_done1", 32'(done), 0);
    end
  endtask

  task automatic do_write(input int a, input logic [CELL_W-1:0] d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (a < N_CELLS) exp_cells[a] = d;
  endtask

  // Requests a rotation, counts busy cycles, and checks the single done pulse.
  // With noise set, random strobes are driven while busy; all of them must be dropped.
  task automatic do_rotate(input int steps, input bit dir, input bit noise);
    int  bc;
    bit  seen;
    rot_start = 1'b1; rot_steps = ADDR_W'(steps); rot_dir = dir;
    bc = 0; seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      rot_start = 1'b0; load = 1'b0; wr_en = 1'b0;
      if (done) begin
        seen = 1'b1;
        chk("rot_busy_at_done", 32'(busy), 0);
      end else if (busy) begin
        bc++;
        if (noise) begin
          load      = 1'($urandom_range(0, 1));
          wr_en     = 1'($urandom_range(0, 1));
          rot_start = 1'($urandom_range(0, 1));
          wr_addr   = ADDR_W'($urandom_range(0, N_CELLS - 1));
          wr_data   = CELL_W'($urandom);
          edge_in   = {$urandom, $urandom, $urandom};
          center_in = 48'({$urandom, $urandom});
          rot_steps = ADDR_W'($urandom_range(1, 20));
        end
      end
    end
    chk("rot_done_seen", 32'(seen), 1);
    chk("rot_busy_cycles", 32'(bc), 32'(steps));
    @(negedge clk);
    chk("rot_done_width", 32'(done), 0);
    chk("rot_busy_after", 32'(busy), 0);
    model_rotate(steps, dir);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int done_cnt;
    rst = 1'b1; load = 1'b0; edge_in = '0; center_in = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    rot_start = 1'b0; rot_steps = '0; rot_dir = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset_rd_data", 32'(rd_data), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    rst = 1'b0;
    sweep("reset_sweep");

    // Directed bulk load and the single-step forward rotation
    do_load(96'h0123456789ABCDEF01234567, 48'h89ABCDEF0123, 1'b0);
    read_one(0,  4'h0, "dir_rd0");
    read_one(1,  4'h1, "dir_rd1");
    read_one(23, 4'h7, "dir_rd23");
    read_one(24, 4'h8, "dir_rd24");
    read_one(35, 4'h3, "dir_rd35");
    do_rotate(1, 1'b0, 1'b0);
    read_one(0,  4'h7, "rot1_cell0");
    read_one(1,  4'h0, "rot1_cell1");
    read_one(24, 4'h8, "rot1_cell24");

    // Full-ring rotation restores the ring; zero steps completes with no change
    do_rotate(24, 1'b0, 1'b1);
    sweep("rot24_sweep");
    do_rotate(0, 1'b0, 1'b0);
    sweep("rot0_sweep");
    do_rotate(5, 1'b1, 1'b1);
    sweep("rot5r_sweep");

    // Load beats write and rotation in the same cycle
    do_load({$urandom, $urandom, $urandom}, 48'({$urandom, $urandom}), 1'b1);
    read_one(5, model_rd(5), "load_prio_cell5");
    sweep("load_prio_sweep");

    // Writes to addresses past the last cell are dropped, and reads there return 0
    do_write(40, 4'hF);
    do_write(7, 4'hA);
    read_one(40, 4'h0, "oob_read");
    sweep("oob_sweep");

    // Random mix of operations
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: do_load({$urandom, $urandom, $urandom}, 48'({$urandom, $urandom}), 1'b0);
        1: do_write($urandom_range(0, 45), CELL_W'($urandom));
        2: do_rotate($urandom_range(0, 30), 1'($urandom_range(0, 1)), 1'b1);
        default: begin
          int a;
          a = $urandom_range(0, 45);
          read_one(a, model_rd(a), "rand_read");
        end
      endcase
    end
    sweep("rand_sweep");

    // Reset after the third step of a ten-step rotation
    rot_start = 1'b1; rot_steps = 6'd10; rot_dir = 1'b0;
    @(negedge clk);
    rot_start = 1'b0;
    chk("midrst_busy_before", 32'(busy), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_rd", 32'(rd_data), 0);
    rst = 1'b0;
    model_clear();
    done_cnt = 0;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("midrst_no_done", 32'(done_cnt), 0);
    sweep("midrst_sweep");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_board_memory.md
TILE_BOARD_MEMORY -- requirements
Module: tile_board_memory

Interface
REQ-001 SHALL have parameter CELL_W, default 4, bit width of one tile cell.
REQ-002 SHALL have parameter N_EDGE, default 24, number of edge-ring cells (cells 0..N_EDGE-1).
REQ-003 SHALL have parameter N_CENTER, default 12, number of center cells (cells N_EDGE..N_EDGE+N_CENTER-1).
REQ-004 SHALL have parameter ADDR_W, default 6, cell address width; must satisfy 2^ADDR_W >= N_EDGE+N_CENTER.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port load, input, 1, bulk-load strobe.
REQ-008 SHALL have port edge_in, input, N_EDGE*CELL_W, edge-ring bulk data.
REQ-009 SHALL have port center_in, input, N_CENTER*CELL_W, center bulk data.
REQ-010 SHALL have port wr_en, input, 1, single-cell write strobe.
REQ-011 SHALL have port wr_addr, input, ADDR_W, single-cell write address.
REQ-012 SHALL have port wr_data, input, CELL_W, single-cell write data.
REQ-013 SHALL have port rd_addr, input, ADDR_W, read address.
REQ-014 SHALL have port rd_data, output, CELL_W, registered read data.
REQ-015 SHALL have port rot_start, input, 1, edge-ring rotation request.
REQ-016 SHALL have port rot_steps, input, ADDR_W, number of single-position rotation steps.
REQ-017 SHALL have port rot_dir, input, 1, 0 = forward, 1 = reverse.
REQ-018 SHALL have port busy, output, 1, rotation in progress.
REQ-019 SHALL have port done, output, 1, one-cycle rotation-complete pulse.

Function
REQ-020 SHALL map bulk load with cell k (k < N_EDGE) = edge_in[(N_EDGE-k)*CELL_W-1 -: CELL_W] (cell 0 = MSB slice), and cell N_EDGE+j = center_in[(N_CENTER-j)*CELL_W-1 -: CELL_W]; all cells written in the same edge, no overlapping slices.
REQ-021 SHALL implement FSM states IDLE, ROTATE, DONE.
REQ-022 SHALL, in IDLE, accept requests by priority load > rot_start > wr_en; only the highest-priority asserted request takes effect that cycle.
REQ-023 SHALL ignore wr_en when wr_addr >= N_EDGE+N_CENTER (no cell changes).
REQ-024 SHALL, on accepted rot_start with rot_steps != 0, latch rot_steps and rot_dir, enter ROTATE, and drive busy=1 from the next cycle.
REQ-025 SHALL, each ROTATE cycle, rotate edge ring one position: forward new[i]=old[(i-1) mod N_EDGE], reverse new[i]=old[(i+1) mod N_EDGE]; center cells never change.
REQ-026 SHALL leave ROTATE for DONE after exactly the latched number of steps; rot_steps >= N_EDGE wraps naturally (e.g. 24 steps with N_EDGE=24 restores the original).
REQ-027 SHALL, on accepted rot_start with rot_steps == 0, go directly to DONE without changing any cell.
REQ-028 SHALL assert done=1 for exactly the one cycle spent in DONE, with busy=0, then return to IDLE.
REQ-029 SHALL ignore load, wr_en, and rot_start while in ROTATE or DONE; no queuing.
REQ-030 SHALL update rd_data every cycle to the cell at rd_addr as of the pre-edge array contents (1-cycle latency, read-before-write), returning 0 when rd_addr >= N_EDGE+N_CENTER; reads are permitted in all states.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, clear all cells to 0, rd_data=0, busy=0, done=0, state=IDLE; rst overrides every other input.
REQ-032 SHALL abort an in-progress rotation on rst with no done pulse.

Verification
REQ-033 Bulk load edge_in=0x0123456789ABCDEF01234567, center_in=0x89ABCDEF0123 -> reading addr 0,1,23,24,35 returns 0x0,0x1,0x7,0x8,0x3.
REQ-034 After REQ-033 load, rot_start steps=1 dir=0 -> busy 1 cycle, done pulse; cell0=0x7, cell1=0x0, cell24 unchanged 0x8.
REQ-035 rot_steps=24 -> busy 24 cycles, then done; array identical to pre-rotation; rot_steps=0 -> done next cycle, busy never high.
REQ-036 Same cycle: load=1, wr_en=1 (addr 5, data 0xF), rot_start=1 -> bulk load only; busy stays 0; cell5 = bulk value.
REQ-037 wr_en during ROTATE and wr_addr=40 in IDLE -> both ignored; rd_addr=40 -> rd_data=0.
REQ-038 rst asserted mid-rotation (step 3 of 10) -> next cycle all cells 0, busy=0, done never pulses.
